tone_gen: RTL and testbench
===========================

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter PRESCALE, default 8: clk cycles per tone tick; legal range 2..256.
REQ-002 Parameter DUR_W, default 12: width of note duration in ticks.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 note_valid  in  1  upstream note request.
REQ-006 note_ready  out  1  block can accept a note; high only in IDLE.
REQ-007 note_addr  in  4  note index, 0..13; 13 = rest.
REQ-008 note_highkey  in  1  key-set select, passed to frequency table.
REQ-009 note_dur  in  DUR_W  note length in ticks.
REQ-010 db_addr  out  4  address to frequency table, registered copy of note_addr.
REQ-011 db_highkey  out  1  key select to frequency table, registered copy of note_highkey.
REQ-012 db_entry  in  8  half-period in ticks from frequency table, combinational response to db_addr/db_highkey; 0 = silence.
REQ-013 audio_out  out  1  square-wave output, registered.
REQ-014 note_done  out  1  one-cycle pulse at note end.
REQ-015 busy  out  1  high in LOAD and PLAY.

Function
REQ-016 FSM states: IDLE, LOAD, PLAY; reset state IDLE.
REQ-017 IDLE: note_ready=1; on note_valid&note_ready at an edge, capture note_addr, note_highkey, note_dur into db_addr, db_highkey, dur_cnt; next state LOAD.
REQ-018 LOAD lasts exactly one cycle: at its closing edge latch period<=db_entry, clear prescale counter and half counter, audio_out<=0; next state PLAY.
REQ-019 PLAY: prescale counter increments each cycle; a tick occurs in the cycle it equals PRESCALE-1, and at that edge it wraps to 0.
REQ-020 On each tick with period!=0 and note not ending: if half counter==period-1 then toggle audio_out and clear half counter, else increment half counter; audio half-period = period*PRESCALE clk cycles.
REQ-021 period==0 (rest or address>=13): audio_out held 0 for whole note, timing otherwise identical.
REQ-022 Each tick decrements dur_cnt; note ends on the tick where dur_cnt is 1 or 0, so a note lasts max(note_dur,1) ticks.
REQ-023 At note-end edge: state<=IDLE, audio_out<=0, note_done<=1 for exactly one cycle; no toggle on that tick.
REQ-024 note_done cycle coincides with first IDLE cycle; note_ready=1 in it; a note accepted then starts LOAD next cycle (back-to-back, 2-cycle gap minimum between PLAY periods).
REQ-025 note_valid while busy is ignored; input fields are not sampled.
REQ-026 db_addr/db_highkey stable from capture until next accept.
REQ-027 Counter widths: prescale counter ceil(log2(PRESCALE)) bits; half counter 8 bits; no overflow possible.

Reset
REQ-028 rst at any edge, including mid-LOAD or mid-PLAY, forces: state IDLE, audio_out 0, note_done 0, busy 0, note_ready 1, db_addr 0, db_highkey 0, period 0, all counters 0.
REQ-029 A handshake coincident with rst is discarded.

Structure
REQ-030 Shared package holds: FSM state enum, PRESCALE default, DUR_W default, REST_ADDR=13 constant.
REQ-031 One sub-module tick_gen (prescale counter, enable, clear, tick output); remaining logic in tone_gen.
REQ-032 tone_gen instantiates no frequency table; db_* ports connect externally.

Verification (bench models table: addr0/low=51, addr0/high=48, addr13=0; PRESCALE=2)
REQ-033 Accept addr0, low, dur=10 -> LOAD 1 cycle, audio_out toggles every 102 cycles, note_done pulses 20 cycles after PLAY entry, audio_out 0 after.
REQ-034 Accept addr0, high, dur=200 -> half-period 96 cycles measured over >=3 toggles.
REQ-035 Accept addr13, dur=5 -> audio_out 0 throughout, note_done exactly 10 cycles after PLAY entry.
REQ-036 dur=0 and dur=1 -> both end after 1 tick (2 cycles of PLAY), no toggle.
REQ-037 note_valid held high continuously -> notes back-to-back, note_valid during PLAY ignored, one accept per note_done.
REQ-038 rst asserted mid-PLAY with audio_out=1 -> next edge audio_out 0, IDLE, note_ready 1, no note_done.

Source files
------------

// File: rtl/tone_gen_pkg.sv
// Shared types and constants for the square-wave tone generator.
// Holds the FSM state encoding and the default parameter values.
package tone_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam int PRESCALE_DEF = 8;
    localparam int DUR_W_DEF    = 12;
    localparam logic [3:0] REST_ADDR = 4'd13;

endpackage

// File: rtl/tone_gen_tick_gen.sv
// Prescaler for the tone generator: pulses tick once every PRESCALE enabled cycles.
// The pulse falls in the cycle where the count equals PRESCALE-1.
module tick_gen
    import tone_gen_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Note player: accepts a note, looks up its half-period in an external table,
// and plays a square wave for the requested number of ticks.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int DUR_W    = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_addr,
    input  logic             note_highkey,
    input  logic [DUR_W-1:0] note_dur,
    output logic [3:0]       db_addr,
    output logic             db_highkey,
    input  logic [7:0]       db_entry,
    output logic             audio_out,
    output logic             note_done,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [DUR_W-1:0] dur_cnt;
    logic [7:0]       period;
    logic [7:0]       half_cnt;
    logic             tick;
    logic             accept;
    logic             note_end;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == PLAY),
        .clr  (state == LOAD),
        .tick (tick)
    );

    assign accept   = note_valid && note_ready;
    // A zero count ends on its first tick, same as a count of one.
    assign note_end = tick && ((dur_cnt == '0) || (dur_cnt == DUR_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = PLAY;
            PLAY:    if (note_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        note_ready = (state == IDLE);
        busy       = (state == LOAD) || (state == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_addr    <= '0;
            db_highkey <= 1'b0;
            dur_cnt    <= '0;
            period     <= '0;
            half_cnt   <= '0;
            audio_out  <= 1'b0;
            note_done  <= 1'b0;
        end else begin
            note_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        db_addr    <= note_addr;
                        db_highkey <= note_highkey;
                        dur_cnt    <= note_dur;
                    end
                end
                LOAD: begin
                    // Out-of-range addresses play as rests whatever the table returns.
                    period    <= (db_addr >= REST_ADDR) ? 8'd0 : db_entry;
                    half_cnt  <= '0;
                    audio_out <= 1'b0;
                end
                PLAY: begin
                    if (note_end) begin
                        dur_cnt   <= '0;
                        audio_out <= 1'b0;
                        note_done <= 1'b1;
                    end else if (tick) begin
                        dur_cnt <= dur_cnt - 1'b1;
                        if (period != 8'd0) begin
                            if (half_cnt == period - 8'd1) begin
                                audio_out <= ~audio_out;
                                half_cnt  <= '0;
                            end else begin
                                half_cnt <= half_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen with PRESCALE=2 and a small behavioural frequency table.
module tb_tone_gen;

    localparam int PRESCALE = 2;
    localparam int DUR_W    = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             note_valid;
    logic             note_ready;
    logic [3:0]       note_addr;
    logic             note_highkey;
    logic [DUR_W-1:0] note_dur;
    logic [3:0]       db_addr;
    logic             db_highkey;
    logic [7:0]       db_entry;
    logic             audio_out;
    logic             note_done;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        db_entry = 8'd0;
        if (db_addr == 4'd0) db_entry = db_highkey ? 8'd48 : 8'd51;
    end

    tone_gen #(.PRESCALE(PRESCALE), .DUR_W(DUR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_addr    (note_addr),
        .note_highkey (note_highkey),
        .note_dur     (note_dur),
        .db_addr      (db_addr),
        .db_highkey   (db_highkey),
        .db_entry     (db_entry),
        .audio_out    (audio_out),
        .note_done    (note_done),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays one note; times are counted in cycles from the first PLAY cycle.
    task automatic run_note(input logic [3:0] a, input logic hk, input int d,
                            output int done_k, output int ntog,
                            output int t1, output int t2, output int t3);
        logic prev;
        int   ready_in_play;
        done_k = -1; ntog = 0; t1 = -1; t2 = -1; t3 = -1;
        ready_in_play = 0;
        note_addr = a; note_highkey = hk; note_dur = DUR_W'(d); note_valid = 1'b1;
        step();
        chk("load_busy", int'(busy), 1);
        chk("load_ready", int'(note_ready), 0);
        chk("load_db_addr", int'(db_addr), int'(a));
        chk("load_db_highkey", int'(db_highkey), int'(hk));
        note_valid = 1'b0; note_addr = 4'd7; note_highkey = ~hk; note_dur = DUR_W'(3);
        step();
        prev = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (note_done === 1'b1) begin
                done_k = k;
                break;
            end
            if (note_ready !== 1'b0) ready_in_play++;
            if (audio_out !== prev) begin
                ntog++;
                if (ntog == 1) t1 = k;
                else if (ntog == 2) t2 = k;
                else if (ntog == 3) t3 = k;
                prev = audio_out;
            end
            step();
        end
        if (done_k < 0) begin
            chk("note_done_timeout", 0, 1);
        end else begin
            chk("ready_during_play", ready_in_play, 0);
            chk("done_audio", int'(audio_out), 0);
            chk("done_ready", int'(note_ready), 1);
            chk("done_busy", int'(busy), 0);
            chk("done_db_addr_stable", int'(db_addr), int'(a));
            step();
            chk("done_one_cycle", int'(note_done), 0);
        end
    endtask

    initial begin
        int dk, nt, ta, tb, tc;
        int acc, dn, last, gap_bad, addr_bad, done_bad;

        rst = 1'b1; note_valid = 1'b1; note_addr = 4'd3; note_highkey = 1'b1;
        note_dur = DUR_W'(4);
        step();
        step();
        chk("rst_ready", int'(note_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_audio", int'(audio_out), 0);
        chk("rst_done", int'(note_done), 0);
        chk("rst_db_addr", int'(db_addr), 0);
        chk("rst_db_highkey", int'(db_highkey), 0);
        note_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_after_rst", int'(busy), 0);

        run_note(4'd0, 1'b0, 10, dk, nt, ta, tb, tc);
        chk("low10_done_k", dk, 20);
        chk("low10_toggles", nt, 0);

        run_note(4'd0, 1'b0, 120, dk, nt, ta, tb, tc);
        chk("low120_done_k", dk, 240);
        chk("low120_toggles", nt, 2);
        chk("low120_first_toggle", ta, 102);
        chk("low120_half_period", tb - ta, 102);

        run_note(4'd0, 1'b1, 200, dk, nt, ta, tb, tc);
        chk("high200_done_k", dk, 400);
        chk("high200_toggles", nt, 4);
        chk("high200_first_toggle", ta, 96);
        chk("high200_half1", tb - ta, 96);
        chk("high200_half2", tc - tb, 96);

        run_note(4'd13, 1'b0, 5, dk, nt, ta, tb, tc);
        chk("rest5_done_k", dk, 10);
        chk("rest5_toggles", nt, 0);

        run_note(4'd0, 1'b0, 0, dk, nt, ta, tb, tc);
        chk("dur0_done_k", dk, 2);
        chk("dur0_toggles", nt, 0);

        run_note(4'd0, 1'b1, 1, dk, nt, ta, tb, tc);
        chk("dur1_done_k", dk, 2);
        chk("dur1_toggles", nt, 0);

        // Back-to-back: valid held high, fields scrambled while busy.
        acc = 0; dn = 0; last = -1; gap_bad = 0; addr_bad = 0; done_bad = 0;
        note_valid = 1'b1; note_highkey = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (note_ready) begin
                note_addr = 4'd13; note_dur = DUR_W'(2);
            end else begin
                note_addr = 4'd14; note_dur = DUR_W'(9);
            end
            if (note_done) begin
                dn++;
                if (!note_ready) done_bad++;
            end
            if (busy && db_addr != 4'd13) addr_bad++;
            if (note_valid && note_ready) begin
                if (last >= 0 && c - last != 6) gap_bad++;
                last = c;
                acc++;
            end
            step();
        end
        note_valid = 1'b0;
        step();
        chk("b2b_accepts", acc, 10);
        chk("b2b_dones", dn, 9);
        chk("b2b_gap", gap_bad, 0);
        chk("b2b_db_addr_held", addr_bad, 0);
        chk("b2b_done_with_ready", done_bad, 0);
        chk("b2b_idle_after", int'(busy), 0);

        // Reset in the middle of a note while the output is high.
        note_addr = 4'd0; note_highkey = 1'b1; note_dur = DUR_W'(200); note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        step();
        for (int k = 0; k < 300; k++) begin
            if (audio_out === 1'b1) break;
            step();
        end
        chk("midplay_audio_high", int'(audio_out), 1);
        rst = 1'b1;
        step();
        chk("midrst_audio", int'(audio_out), 0);
        chk("midrst_ready", int'(note_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(note_done), 0);
        chk("midrst_db_addr", int'(db_addr), 0);
        chk("midrst_db_highkey", int'(db_highkey), 0);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (note_done) dn++;
            step();
        end
        chk("midrst_no_done", dn, 0);
        chk("midrst_stays_idle", int'(busy), 0);

        run_note(4'd13, 1'b0, 1, dk, nt, ta, tb, tc);
        chk("recover_done_k", dk, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
